// File: rtl/lc3b_types.sv
// Shared LC-3b widths plus the pipeline controller's state encoding.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    // RUN: normal sequencing. DRAIN: a redirect is waiting for a stale fetch to finish.
    typedef enum logic {
        PC_RUN   = 1'b0,
        PC_DRAIN = 1'b1
    } pipe_ctrl_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic lc3b_word sat_inc(input lc3b_word value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Detects an ID-stage instruction reading the register a load in EX is still fetching.
module load_use_detect (
    input  logic       valid_id,
    input  logic       valid_ex,
    input  logic       ex_is_load,
    input  logic [2:0] ex_dest,
    input  logic [2:0] id_src1,
    input  logic [2:0] id_src2,
    input  logic       id_uses_src1,
    input  logic       id_uses_src2,
    output logic       load_use
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = id_uses_src1 & (id_src1 == ex_dest);
    assign src2_hit = id_uses_src2 & (id_src2 == ex_dest);
    assign load_use = valid_id & valid_ex & ex_is_load & (src1_hit | src2_hit);

endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous clear.
module register #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] data_q;

    // Clear on reset, otherwise capture din when load is asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the five-stage LC-3b pipeline: buffer/PC load
// enables, stage valid bits, hazard and redirect handling, perf counters.
module pipeline_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [2:0]  id_src1,
    input  logic [2:0]  id_src2,
    input  logic        id_uses_src1,
    input  logic        id_uses_src2,
    input  logic [2:0]  ex_dest,
    input  logic        ex_is_load,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        imem_read,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        pc_sel,
    output logic [15:0] redirect_pc,
    output logic        valid_id,
    output logic        valid_ex,
    output logic        valid_mem,
    output logic        valid_wb,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    pipe_ctrl_state_t state_q, state_d;
    logic     valid_id_q, valid_id_d;
    logic     valid_ex_q, valid_ex_d;
    logic     valid_mem_q, valid_mem_d;
    logic     valid_wb_q, valid_wb_d;
    lc3b_word stall_cycles_q, stall_cycles_d;
    lc3b_word flush_count_q, flush_count_d;
    lc3b_word target_q;
    logic     capture_target;

    logic mem_stall;
    logic flush;
    logic load_use;

    assign mem_stall = valid_mem_q & dmem_req & ~dmem_resp;
    assign flush     = valid_mem_q & br_taken & ~mem_stall;

    load_use_detect u_load_use (
        .valid_id     (valid_id_q),
        .valid_ex     (valid_ex_q),
        .ex_is_load   (ex_is_load),
        .ex_dest      (ex_dest),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .load_use     (load_use)
    );

    // Redirect target held across DRAIN while the stale fetch completes.
    register #(.width(16)) u_target (
        .clk   (clk),
        .reset (reset),
        .load  (capture_target),
        .din   (br_target),
        .dout  (target_q)
    );

    // In DRAIN the PC must take the captured target; otherwise the live one.
    assign redirect_pc = (state_q == PC_DRAIN) ? target_q : br_target;
    assign imem_read   = ~reset;

    // Next-state, valid-bit and load-enable decode in priority order.
    always_comb begin
        state_d        = state_q;
        valid_id_d     = valid_id_q;
        valid_ex_d     = valid_ex_q;
        valid_mem_d    = valid_mem_q;
        valid_wb_d     = valid_wb_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        load_pc        = 1'b0;
        load_if_id     = 1'b0;
        load_id_ex     = 1'b0;
        load_ex_mem    = 1'b0;
        load_mem_wb    = 1'b0;
        pc_sel         = 1'b0;
        capture_target = 1'b0;

        if (!reset) begin
            if (mem_stall | load_use | (~imem_resp & ~flush)) begin
                stall_cycles_d = sat_inc(stall_cycles_q);
            end
            if (flush) begin
                flush_count_d = flush_count_q + 16'd1;
            end

            if (mem_stall) begin
                // Freeze everything upstream of MEM; WB receives a bubble.
                load_mem_wb = 1'b1;
                valid_wb_d  = 1'b0;
            end else if (flush) begin
                // The branch retires into WB; everything younger is squashed.
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                valid_id_d  = 1'b0;
                valid_ex_d  = 1'b0;
                valid_mem_d = 1'b0;
                valid_wb_d  = 1'b1;
                if (imem_resp) begin
                    load_pc = 1'b1;
                    pc_sel  = 1'b1;
                    state_d = PC_RUN;
                end else begin
                    capture_target = 1'b1;
                    state_d        = PC_DRAIN;
                end
            end else begin
                // EX and beyond always advance here.
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                valid_mem_d = valid_ex_q;
                valid_wb_d  = valid_mem_q;
                if (load_use) begin
                    // Hold IF/ID and PC; inject one bubble into EX.
                    valid_ex_d = 1'b0;
                end else begin
                    valid_ex_d = valid_id_q;
                    load_if_id = 1'b1;
                    if (state_q == PC_DRAIN) begin
                        // Whatever the stale fetch returns is discarded.
                        valid_id_d = 1'b0;
                        if (imem_resp) begin
                            load_pc = 1'b1;
                            pc_sel  = 1'b1;
                            state_d = PC_RUN;
                        end
                    end else begin
                        load_pc    = imem_resp;
                        valid_id_d = imem_resp;
                    end
                end
            end
        end
    end

    // State, valid bits and counters; reset clears all of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= PC_RUN;
            valid_id_q     <= 1'b0;
            valid_ex_q     <= 1'b0;
            valid_mem_q    <= 1'b0;
            valid_wb_q     <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            valid_id_q     <= valid_id_d;
            valid_ex_q     <= valid_ex_d;
            valid_mem_q    <= valid_mem_d;
            valid_wb_q     <= valid_wb_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign valid_id     = valid_id_q;
    assign valid_ex     = valid_ex_q;
    assign valid_mem    = valid_mem_q;
    assign valid_wb     = valid_wb_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one task per scenario, inline checks.
module tb_pipeline_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [2:0]  id_src1, id_src2, ex_dest;
    logic        id_uses_src1, id_uses_src2, ex_is_load;
    logic        br_taken;
    logic [15:0] br_target;
    logic        imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, pc_sel;
    logic [15:0] redirect_pc, stall_cycles, flush_count;
    logic        valid_id, valid_ex, valid_mem, valid_wb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_dest(ex_dest),
        .ex_is_load(ex_is_load), .br_taken(br_taken), .br_target(br_target),
        .imem_read(imem_read), .load_pc(load_pc), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .pc_sel(pc_sel), .redirect_pc(redirect_pc), .valid_id(valid_id),
        .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // A taken branch in MEM while draining would mean EX/MEM were not flushed.
    always @(negedge clk) begin
        if (!reset && dut.state_q == PC_DRAIN && valid_mem && br_taken) begin
            errors++;
            $display("FAIL drain_branch br_taken with valid_mem while in DRAIN");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_src1 = 3'd0; id_src2 = 3'd0; id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
        ex_dest = 3'd7; ex_is_load = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Four fetch hits fill ID/EX/MEM/WB with real instructions.
    task automatic fill_pipe();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        br_taken = 1'b1;
        #1;
        checks++; if ({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 5'b0) begin errors++; $display("FAIL reset_loads got %b want 00000", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}); end
        checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_imem_read got %b want 0", imem_read); end
        checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL reset_pc_sel got %b want 0", pc_sel); end
        tick();
        tick();
        checks++; if ({valid_id, valid_ex, valid_mem, valid_wb} !== 4'b0) begin errors++; $display("FAIL reset_valids got %b want 0000", {valid_id, valid_ex, valid_mem, valid_wb}); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL reset_counters got %h/%h want 0000/0000", stall_cycles, flush_count); end
        reset = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_fetch();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++; if (load_pc !== 1'b1 || imem_read !== 1'b1) begin errors++; $display("FAIL fetch_load_pc c%0d got %b/%b want 1/1", c, load_pc, imem_read); end
            checks++; if (valid_wb !== (c >= 5)) begin errors++; $display("FAIL fetch_valid_wb c%0d got %b want %b", c, valid_wb, (c >= 5)); end
            tick();
        end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL fetch_counters got %h/%h want 0000/0000", stall_cycles, flush_count); end
        $display("fetch: 5 cycles, valid_wb=%b", valid_wb);
    endtask

    task automatic test_load_use();
        do_reset();
        fill_pipe();
        // LDR R1 in EX, ADD R2,R1,R3 in ID.
        ex_is_load = 1'b1; ex_dest = 3'd1;
        id_src1 = 3'd1; id_uses_src1 = 1'b1; id_src2 = 3'd3; id_uses_src2 = 1'b1;
        #1;
        checks++; if ({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 5'b00111) begin errors++; $display("FAIL lu_loads got %b want 00111", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}); end
        tick();
        checks++; if ({valid_id, valid_ex, valid_mem, valid_wb} !== 4'b1011) begin errors++; $display("FAIL lu_valids got %b want 1011", {valid_id, valid_ex, valid_mem, valid_wb}); end
        checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_stall_cycles got %0d want 1", stall_cycles); end
        #1;
        checks++; if (load_pc !== 1'b1 || load_if_id !== 1'b1) begin errors++; $display("FAIL lu_resume got %b/%b want 1/1", load_pc, load_if_id); end
        tick();
        checks++; if (valid_ex !== 1'b1 || stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_after got ex=%b stall=%0d want 1/1", valid_ex, stall_cycles); end
        $display("load_use: stall_cycles=%0d", stall_cycles);
        idle_inputs();
    endtask

    task automatic test_data_wait();
        do_reset();
        fill_pipe();
        dmem_req = 1'b1; dmem_resp = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if ({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 5'b00001) begin errors++; $display("FAIL dw_loads c%0d got %b want 00001", c, {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}); end
            tick();
            checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL dw_valid_wb c%0d got %b want 0", c, valid_wb); end
        end
        dmem_resp = 1'b1;
        #1;
        checks++; if (load_pc !== 1'b1 || load_ex_mem !== 1'b1) begin errors++; $display("FAIL dw_release got %b/%b want 1/1", load_pc, load_ex_mem); end
        tick();
        checks++; if (valid_wb !== 1'b1) begin errors++; $display("FAIL dw_valid_wb_after got %b want 1", valid_wb); end
        checks++; if (stall_cycles !== 16'd4) begin errors++; $display("FAIL dw_stall_cycles got %0d want 4", stall_cycles); end
        $display("data_wait: stall_cycles=%0d", stall_cycles);
        idle_inputs();
    endtask

    task automatic test_flush_hit();
        do_reset();
        fill_pipe();
        br_taken = 1'b1; br_target = 16'h3000;
        #1;
        checks++; if (pc_sel !== 1'b1 || load_pc !== 1'b1) begin errors++; $display("FAIL fh_pc got sel=%b load=%b want 1/1", pc_sel, load_pc); end
        checks++; if (redirect_pc !== 16'h3000) begin errors++; $display("FAIL fh_redirect got %h want 3000", redirect_pc); end
        checks++; if ({load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 4'b1111) begin errors++; $display("FAIL fh_loads got %b want 1111", {load_if_id, load_id_ex, load_ex_mem, load_mem_wb}); end
        tick();
        br_taken = 1'b0;
        checks++; if ({valid_id, valid_ex, valid_mem, valid_wb} !== 4'b0001) begin errors++; $display("FAIL fh_valids got %b want 0001", {valid_id, valid_ex, valid_mem, valid_wb}); end
        checks++; if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin errors++; $display("FAIL fh_counters got %0d/%0d want 1/0", flush_count, stall_cycles); end
        #1;
        checks++; if (pc_sel !== 1'b0 || load_pc !== 1'b1) begin errors++; $display("FAIL fh_next got sel=%b load=%b want 0/1", pc_sel, load_pc); end
        // Exactly three bubbles reach WB after the branch.
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (valid_wb !== (c == 4)) begin errors++; $display("FAIL fh_bubble c%0d got %b want %b", c, valid_wb, (c == 4)); end
        end
        $display("flush_hit: flush_count=%0d", flush_count);
    endtask

    task automatic test_flush_miss();
        do_reset();
        fill_pipe();
        br_taken = 1'b1; br_target = 16'h3000; imem_resp = 1'b0;
        #1;
        checks++; if (load_pc !== 1'b0 || load_if_id !== 1'b1) begin errors++; $display("FAIL fm_flush got pc=%b ifid=%b want 0/1", load_pc, load_if_id); end
        tick();
        br_taken = 1'b0; br_target = 16'h1234;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (load_pc !== 1'b0 || imem_read !== 1'b1 || redirect_pc !== 16'h3000) begin errors++; $display("FAIL fm_drain c%0d got pc=%b rd=%b tgt=%h want 0/1/3000", c, load_pc, imem_read, redirect_pc); end
            tick();
        end
        imem_resp = 1'b1;
        #1;
        checks++; if (load_pc !== 1'b1 || pc_sel !== 1'b1 || load_if_id !== 1'b1) begin errors++; $display("FAIL fm_resp got pc=%b sel=%b ifid=%b want 1/1/1", load_pc, pc_sel, load_if_id); end
        checks++; if (redirect_pc !== 16'h3000) begin errors++; $display("FAIL fm_redirect got %h want 3000", redirect_pc); end
        tick();
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL fm_discard got %b want 0", valid_id); end
        #1;
        checks++; if (pc_sel !== 1'b0 || load_pc !== 1'b1) begin errors++; $display("FAIL fm_run got sel=%b pc=%b want 0/1", pc_sel, load_pc); end
        checks++; if (flush_count !== 16'd1 || stall_cycles !== 16'd3) begin errors++; $display("FAIL fm_counters got %0d/%0d want 1/3", flush_count, stall_cycles); end
        $display("flush_miss: stall_cycles=%0d flush_count=%0d", stall_cycles, flush_count);
    endtask

    task automatic test_stall_flush_reset();
        do_reset();
        fill_pipe();
        dmem_req = 1'b1; dmem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h4000; imem_resp = 1'b0;
        #1;
        checks++; if (pc_sel !== 1'b0 || load_ex_mem !== 1'b0 || load_mem_wb !== 1'b1) begin errors++; $display("FAIL sf_stall got sel=%b exmem=%b memwb=%b want 0/0/1", pc_sel, load_ex_mem, load_mem_wb); end
        tick();
        checks++; if (flush_count !== 16'd0 || valid_mem !== 1'b1) begin errors++; $display("FAIL sf_deferred got fc=%0d vm=%b want 0/1", flush_count, valid_mem); end
        dmem_resp = 1'b1;
        #1;
        checks++; if (load_ex_mem !== 1'b1 || load_pc !== 1'b0) begin errors++; $display("FAIL sf_flush got exmem=%b pc=%b want 1/0", load_ex_mem, load_pc); end
        tick();
        dmem_req = 1'b0; dmem_resp = 1'b0; br_taken = 1'b0; br_target = 16'h5555;
        #1;
        checks++; if (flush_count !== 16'd1 || redirect_pc !== 16'h4000) begin errors++; $display("FAIL sf_drain got fc=%0d tgt=%h want 1/4000", flush_count, redirect_pc); end
        reset = 1'b1;
        #1;
        checks++; if ({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, imem_read} !== 6'b0) begin errors++; $display("FAIL sf_reset_outs got %b want 000000", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, imem_read}); end
        tick();
        reset = 1'b0; imem_resp = 1'b1;
        #1;
        checks++; if ({valid_id, valid_ex, valid_mem, valid_wb} !== 4'b0) begin errors++; $display("FAIL sf_reset_valids got %b want 0000", {valid_id, valid_ex, valid_mem, valid_wb}); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL sf_reset_counters got %h/%h want 0000/0000", stall_cycles, flush_count); end
        checks++; if (pc_sel !== 1'b0 || load_pc !== 1'b1 || redirect_pc !== 16'h5555) begin errors++; $display("FAIL sf_reset_run got sel=%b pc=%b tgt=%h want 0/1/5555", pc_sel, load_pc, redirect_pc); end
        $display("stall_flush_reset: back in RUN");
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_fetch();
        test_load_use();
        test_data_wait();
        test_flush_hit();
        test_flush_miss();
        test_stall_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the five-stage LC-3b core (IF, ID, EX, MEM, WB). It drives the `load` inputs of the four inter-stage `buffer` instances (`if_id`, `id_ex`, `ex_mem`, `mem_wb`) and the PC register. It owns the per-stage valid bits that mark bubbles, and resolves instruction-memory waits, data-memory waits, load-use hazards and taken-branch flushes. It sits beside the datapath, consumes decoded fields from the buffer outputs, and also holds two performance counters.

## Interface
- No parameters; widths come from `lc3b_types` (`lc3b_reg` = 3 bits, `lc3b_word` = 16 bits).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_resp` in 1: I-cache hit/response for the current fetch.
- `dmem_req` in 1: instruction in MEM needs data memory (LDR/STR/LDB/STB/LDI/STI).
- `dmem_resp` in 1: D-cache response.
- `id_src1`, `id_src2` in lc3b_reg: source registers of the instruction in ID.
- `id_uses_src1`, `id_uses_src2` in 1: the ID instruction reads that source.
- `ex_dest` in lc3b_reg: destination of the instruction in EX.
- `ex_is_load` in 1: the EX instruction writes a register from memory.
- `br_taken` in 1: the MEM-stage branch/JMP/JSR/TRAP redirects.
- `br_target` in lc3b_word: redirect address, valid with `br_taken`.
- `imem_read` out 1: fetch request.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: buffer/PC load enables.
- `pc_sel` out 1: 1 selects `redirect_pc` into the PC; 0 selects PC+2.
- `redirect_pc` out lc3b_word: redirect address.
- `valid_id`, `valid_ex`, `valid_mem`, `valid_wb` out 1 each: stage holds a real instruction. WB regfile/CC writes are gated by `valid_wb`.
- `stall_cycles`, `flush_count` out lc3b_word: performance counters.

## Operation
- **Memory contract:** caches hold `*_resp` high every cycle that the request is held to a hitting address.
- **Definitions:**
  - `mem_stall` = `valid_mem & dmem_req & ~dmem_resp`
  - `flush` = `valid_mem & br_taken & ~mem_stall`
  - `load_use` = `valid_id & valid_ex & ex_is_load & ((id_uses_src1 & id_src1==ex_dest) | (id_uses_src2 & id_src2==ex_dest))`
- **Priority:** `reset` > `mem_stall` > `flush` > `load_use` > fetch wait.
- **`mem_stall`:** `load_mem_wb`=1 with `valid_wb`<=0; all other loads are 0.
- **`flush`:**
  - All four buffers load; `valid_wb`<=1; `valid_id`, `valid_ex`, `valid_mem`<=0; `flush_count`+1 (wraps).
  - If `imem_resp`=1: `load_pc`=1, `pc_sel`=1, `redirect_pc`=`br_target`.
  - If `imem_resp`=0: capture `br_target`, `load_pc`=0, go to DRAIN.
- **`load_use`:** `load_pc`=`load_if_id`=0; `load_id_ex`=1 with `valid_ex`<=0. EX/MEM and MEM/WB advance normally.
- **Normal advance:** every buffer loads; each valid bit <= the previous stage's valid bit. For IF to ID:
  - `imem_resp`=1: `load_pc`=1, `valid_id`<=1.
  - `imem_resp`=0: `load_pc`=0, `load_if_id`=1, `valid_id`<=0 (bubble).
- **FSM:**
  - RUN: as above.
  - DRAIN: the stale fetch completes. `imem_read` stays 1 and `redirect_pc` = captured target.
  - On `imem_resp` in DRAIN (and no `mem_stall`): `load_pc`=1, `pc_sel`=1, `load_if_id`=1 with `valid_id`<=0 (fetch discarded), then return to RUN. Downstream stages keep advancing while in DRAIN.
  - `br_taken` with `valid_mem` in DRAIN cannot occur (EX/MEM were flushed); the bench asserts this.
- `imem_read` = `~reset`.
- `stall_cycles` increments (saturating at 0xFFFF) in any cycle with `mem_stall | load_use | (~imem_resp & ~flush)`.

## Timing
- All load/select outputs are combinational from inputs and state, and take effect on the same edge.
- **Reset:** for the cycle `reset` is high, all `load_*`=0, `pc_sel`=0 and `imem_read`=0. On the edge, valid bits, counters and `redirect_pc`'s stored value are cleared to 0 and the state goes to RUN.
  - The first fetch is requested in the cycle after `reset` falls.
  - `reset` mid-DRAIN abandons the redirect.
- A load-use costs exactly 1 bubble. A flush costs 3 bubbles, plus the imem wait when in DRAIN.
- `mem_stall` and `br_taken` in the same cycle: the stall wins and the flush is taken on the `dmem_resp` cycle.

## Structure
- `lc3b_types` gains the enum `pipe_ctrl_state_t {PC_RUN, PC_DRAIN}`.
- The combinational `load_use` compare is the sub-module `load_use_detect`.
- The captured target uses the existing `register #(.width(16))`.

## Test plan
- **Reset then fetch:** release `reset`, `imem_resp`=1 for 5 cycles. Expect `valid_wb`=1 first at cycle 5, `load_pc`=1 each cycle, counters 0.
- **Load-use:** LDR R1 in EX, ADD R2,R1,R3 in ID. Expect one cycle with `load_pc`=`load_if_id`=0 and `valid_ex`<=0, then ADD advances; `stall_cycles`=1.
- **Data wait:** `dmem_req`=1, `dmem_resp` low for 4 cycles. Expect all loads 0 except `load_mem_wb`, `valid_wb`=0 for 4 cycles, `stall_cycles`=4.
- **Flush with fetch hit:** `br_taken`=1, `br_target`=0x3000. Expect `pc_sel`=1, `redirect_pc`=0x3000, ID/EX/MEM valid bits cleared, `flush_count`=1.
- **Flush during fetch miss:** `br_taken` with `imem_resp`=0 for 3 more cycles. Expect DRAIN; `load_pc`=1 with `redirect_pc`=0x3000 only on the response cycle; discarded fetch gives `valid_id`=0.
- **Stall beats flush, then reset:** `mem_stall` and `br_taken` together: expect the flush deferred to the response cycle. Assert `reset` while in DRAIN: expect all valid bits 0, state RUN, counters 0.
